// File: rtl/pocket_video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pocket_video_pkg                                            |
// | Brief  : Shared timing constants, VRAM geometry and the shade        |
// |          palette for the pocket LCD scan-out path.                   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package pocket_video_pkg;

  // Horizontal timing in pixel clocks
  localparam int H_ACTIVE     = 160;
  localparam int H_FP         = 8;
  localparam int H_SYNC       = 4;
  localparam int H_BP         = 28;
  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  // Vertical timing in lines
  localparam int V_ACTIVE     = 160;
  localparam int V_FP         = 4;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 34;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Four 2-bit pixels per byte, 160 pixels per line
  localparam int VRAM_LINE_BYTES = 40;
  localparam int VRAM_AW         = 13;

  typedef logic [1:0] shade_t;

  // Shade 0 is the lightest (panel white), shade 3 is black
  localparam logic [3:0][23:0] SHADE_RGB = {
    24'h000000,   // shade 3
    24'h555555,   // shade 2
    24'hAAAAAA,   // shade 1
    24'hFFFFFF    // shade 0
  };

  function automatic logic [23:0] shade_to_rgb(input shade_t i_shade);
    return SHADE_RGB[i_shade];
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : video_timing_gen                                            |
// | Brief  : Free-running h/v raster counters with active, sync and      |
// |          frame-start decode (all combinational from the counters).   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module video_timing_gen
  import pocket_video_pkg::*;
(
  input  logic       i_pclk,
  input  logic       i_rst_n,
  output logic [7:0] o_h,
  output logic [7:0] o_v,
  output logic       o_active,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_frame_start
);

  logic [7:0] r_h;
  logic [7:0] r_v;
  logic       w_h_wrap;
  logic       w_v_wrap;

  assign w_h_wrap = (r_h == 8'(H_TOTAL - 1));
  assign w_v_wrap = (r_v == 8'(V_TOTAL - 1));

  // Raster position: h every clock, v on h wrap, both wrap at end of frame
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_wrap) begin
      r_h <= '0;
      r_v <= w_v_wrap ? '0 : r_v + 8'd1;
    end else begin
      r_h <= r_h + 8'd1;
    end
  end

  assign o_h           = r_h;
  assign o_v           = r_v;
  assign o_active      = (r_h < 8'(H_ACTIVE)) && (r_v < 8'(V_ACTIVE));
  assign o_hsync       = (r_h >= 8'(H_SYNC_START)) && (r_h < 8'(H_SYNC_END));
  assign o_vsync       = (r_v >= 8'(V_SYNC_START)) && (r_v < 8'(V_SYNC_END));
  assign o_frame_start = (r_h == 8'd0) && (r_v == 8'd0);

endmodule
`default_nettype wire

// File: rtl/supervision_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : supervision_scanout                                         |
// | Brief  : 2bpp VRAM scan-out. Stage 0 issues byte fetches from the    |
// |          raster position, stage 1 unpacks the returned byte, stage   |
// |          2 registers palette colour and the aligned sync/DE/frame.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module supervision_scanout
  import pocket_video_pkg::*;
(
  input  logic                 iPCLK,
  input  logic                 iRST_N,
  input  logic                 iENABLE,
  input  logic [7:0]           iVRAM_DATA,
  output logic [VRAM_AW-1:0]   oVRAM_ADDR,
  output logic                 oVRAM_RD,
  output logic [23:0]          oRGB,
  output logic                 oHS,
  output logic                 oVS,
  output logic                 oDE,
  output logic                 oFRAME
);

  // ---------------- stage 0: raster position and fetch ----------------
  logic [7:0]         w_h;
  logic [7:0]         w_v;
  logic               w_active;
  logic               w_hsync;
  logic               w_vsync;
  logic               w_frame_start;
  logic               w_fetch;
  logic [VRAM_AW-1:0] w_v_ext;
  logic [VRAM_AW-1:0] w_fetch_addr;
  logic [VRAM_AW-1:0] r_addr_hold;

  video_timing_gen u_timing (
    .i_pclk        (iPCLK),
    .i_rst_n       (iRST_N),
    .o_h           (w_h),
    .o_v           (w_v),
    .o_active      (w_active),
    .o_hsync       (w_hsync),
    .o_vsync       (w_vsync),
    .o_frame_start (w_frame_start)
  );

  // The counters rest at h=0,v=0 (an active fetch slot) while held in
  // reset, so the strobe is qualified by reset to keep it low there.
  assign w_fetch      = iRST_N && w_active && (w_h[1:0] == 2'b00);
  assign w_v_ext      = {5'd0, w_v};
  assign w_fetch_addr = (w_v_ext * VRAM_AW'(VRAM_LINE_BYTES)) + {7'd0, w_h[7:2]};

  // Remember the last issued address so the bus is stable between fetches
  always_ff @(posedge iPCLK or negedge iRST_N) begin
    if (!iRST_N)      r_addr_hold <= '0;
    else if (w_fetch) r_addr_hold <= w_fetch_addr;
  end

  assign oVRAM_ADDR = w_fetch ? w_fetch_addr : r_addr_hold;
  assign oVRAM_RD   = w_fetch;

  // ---------------- stage 1: byte capture and unpack ----------------
  logic       r_s1_active;
  logic       r_s1_fetch;
  logic [1:0] r_s1_pix;
  logic       r_s1_en;
  logic       r_s1_hs;
  logic       r_s1_vs;
  logic       r_s1_frame;
  logic [7:0] r_byte;
  logic [7:0] w_byte;
  shade_t     w_shade;

  // Carry the stage-0 decode one cycle forward, sampling iENABLE here
  always_ff @(posedge iPCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_s1_active <= 1'b0;
      r_s1_fetch  <= 1'b0;
      r_s1_pix    <= 2'd0;
      r_s1_en     <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s1_frame  <= 1'b0;
    end else begin
      r_s1_active <= w_active;
      r_s1_fetch  <= w_fetch;
      r_s1_pix    <= w_h[1:0];
      r_s1_en     <= iENABLE;
      r_s1_hs     <= w_hsync;
      r_s1_vs     <= w_vsync;
      r_s1_frame  <= w_frame_start;
    end
  end

  // Latch the VRAM byte on the cycle it returns, for pixels 1..3
  always_ff @(posedge iPCLK or negedge iRST_N) begin
    if (!iRST_N)         r_byte <= '0;
    else if (r_s1_fetch) r_byte <= iVRAM_DATA;
  end

  // Pixel 0 takes the byte straight off the bus as it is being latched
  assign w_byte = r_s1_fetch ? iVRAM_DATA : r_byte;

  // Leftmost pixel sits in the LSBs; a disabled display shows shade 0
  always_comb begin
    w_shade = 2'b00;
    if (r_s1_en) begin
      case (r_s1_pix)
        2'd0:    w_shade = w_byte[1:0];
        2'd1:    w_shade = w_byte[3:2];
        2'd2:    w_shade = w_byte[5:4];
        default: w_shade = w_byte[7:6];
      endcase
    end
  end

  // ---------------- stage 2: palette and aligned outputs ----------------
  logic [23:0] r_rgb;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic        r_frame;

  // Colour is forced to black outside the active area
  always_ff @(posedge iPCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_rgb   <= '0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_de    <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_rgb   <= r_s1_active ? shade_to_rgb(w_shade) : 24'h000000;
      r_hs    <= r_s1_hs;
      r_vs    <= r_s1_vs;
      r_de    <= r_s1_active;
      r_frame <= r_s1_frame;
    end
  end

  assign oRGB   = r_rgb;
  assign oHS    = r_hs;
  assign oVS    = r_vs;
  assign oDE    = r_de;
  assign oFRAME = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_supervision_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_supervision_scanout                                      |
// | Brief  : Directed bench for supervision_scanout with a pixel         |
// |          scoreboard fed by the stimulus and drained by a monitor.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_supervision_scanout;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  vram_data = 8'h00;
  logic [12:0] addr;
  logic        rd;
  logic [23:0] rgb;
  logic        hs, vs, de, frame;

  int          tests = 0;
  int          fails = 0;
  logic [23:0] exp_q[$];
  bit          mon_en  = 1'b0;
  bit          vram_ff = 1'b1;

  always #5 clk = ~clk;

  supervision_scanout dut (
    .iPCLK      (clk),
    .iRST_N     (rst_n),
    .iENABLE    (en),
    .iVRAM_DATA (vram_data),
    .oVRAM_ADDR (addr),
    .oVRAM_RD   (rd),
    .oRGB       (rgb),
    .oHS        (hs),
    .oVS        (vs),
    .oDE        (de),
    .oFRAME     (frame)
  );

  // VRAM with one cycle of read latency
  always @(posedge clk) begin
    if (rd) vram_data <= vram_ff ? 8'hFF : addr[7:0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected colour of an enabled pixel when VRAM returns addr[7:0]
  function automatic logic [23:0] ref_rgb(input int h, input int v);
    logic [23:0] pal [4];
    int          a;
    logic [7:0]  b;
    int          s;
    pal[0] = 24'hFFFFFF;
    pal[1] = 24'hAAAAAA;
    pal[2] = 24'h555555;
    pal[3] = 24'h000000;
    a = v * 40 + h / 4;
    b = a[7:0];
    s = (int'(b) >> (2 * (h % 4))) & 3;
    return pal[s];
  endfunction

  // Scoreboard monitor: every displayed pixel consumes one expectation
  always @(negedge clk) begin
    if (mon_en && de) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else                   chk("sb_pixel", {8'd0, rgb}, {8'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int h, v;
    int rd_cnt, max_addr, vs_cnt, vs_first, hs_cnt0, hs_first0, de_cnt0;
    logic [23:0] hand_px [4];

    hand_px[0] = 24'hAAAAAA;
    hand_px[1] = 24'h555555;
    hand_px[2] = 24'h555555;
    hand_px[3] = 24'hFFFFFF;

    rd_cnt = 0; max_addr = 0; vs_cnt = 0; vs_first = -1;
    hs_cnt0 = 0; hs_first0 = -1; de_cnt0 = 0;

    rst_n   = 1'b0;
    en      = 1'b0;
    vram_ff = 1'b1;

    // Frame 0: display disabled, VRAM all 0xFF -> every active pixel white
    for (int yv = 0; yv < 160; yv++)
      for (int xh = 0; xh < 160; xh++) exp_q.push_back(24'hFFFFFF);
    // Frame 1: enabled, up to the mid-frame reset at v=80, h=50
    for (int yv = 0; yv <= 80; yv++)
      for (int xh = 0; xh < 160; xh++)
        if (yv < 80 || xh <= 50) exp_q.push_back(ref_rgb(xh, yv));
    mon_en = 1'b1;

    // Held in reset: everything low
    repeat (10) begin
      @(negedge clk);
      chk("reset_rgb", {8'd0, rgb}, 32'd0);
      chk("reset_ctl", {14'd0, addr, rd, hs, vs, de, frame}, 32'd0);
    end

    rst_n = 1'b1;
    @(negedge clk);
    chk("frame_early", {31'd0, frame}, 32'd0);

    // k indexes output cycles; output k shows raster (k%200, k/200)
    for (int k = 0; k <= 56050; k++) begin
      @(negedge clk);
      h = k % 200;
      v = (k / 200) % 200;
      chk("de",    {31'd0, de},    {31'd0, (h < 160 && v < 160)});
      chk("hs",    {31'd0, hs},    {31'd0, (h >= 168 && h <= 171)});
      chk("vs",    {31'd0, vs},    {31'd0, (v >= 164 && v <= 165)});
      chk("frame", {31'd0, frame}, {31'd0, (h == 0 && v == 0)});
      if (!(h < 160 && v < 160)) chk("blank_rgb", {8'd0, rgb}, 32'd0);

      if (k < 40000) begin
        if (rd) begin
          rd_cnt++;
          if (int'(addr) > max_addr) max_addr = int'(addr);
        end
        if (vs) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = k;
        end
      end
      if (k < 200) begin
        if (de) de_cnt0++;
        if (hs) begin
          hs_cnt0++;
          if (hs_first0 < 0) hs_first0 = k;
        end
      end

      // Counter is two cycles ahead of the output being sampled
      if (k == 31954) chk("last_addr", {19'd0, addr, rd}, {19'd0, 13'd6399, 1'b1});
      if (k == 40202) chk("addr_v1h4", {19'd0, addr, rd}, {19'd0, 13'd41, 1'b1});
      if (k >= 40204 && k <= 40207) chk("px_0x29", {8'd0, rgb}, {8'd0, hand_px[k - 40204]});

      if (k == 39998) begin
        en      = 1'b1;
        vram_ff = 1'b0;
      end
    end

    chk("rd_count",  rd_cnt,    6400);
    chk("max_addr",  max_addr,  6399);
    chk("vs_cycles", vs_cnt,    400);
    chk("vs_start",  vs_first,  32800);
    chk("hs_cycles", hs_cnt0,   4);
    chk("hs_start",  hs_first0, 168);
    chk("de_cycles", de_cnt0,   160);

    // Mid-frame reset at output v=80, h=50
    #2 rst_n = 1'b0;
    #1;
    mon_en = 1'b0;
    chk("sb_drained", exp_q.size(), 0);
    chk("async_rgb", {8'd0, rgb}, 32'd0);
    chk("async_ctl", {14'd0, addr, rd, hs, vs, de, frame}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_rgb", {8'd0, rgb}, 32'd0);
      chk("midrst_ctl", {14'd0, addr, rd, hs, vs, de, frame}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("refr_early", {31'd0, frame}, 32'd0);
    @(negedge clk);
    chk("refr_frame", {31'd0, frame}, 32'd1);
    chk("refr_de",    {31'd0, de},    32'd1);
    chk("refr_rgb",   {8'd0, rgb},    32'hFFFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
